// File: rtl/note_scheduler.sv
// note_scheduler: steps through a drum pattern ROM one entry per beat, drives the
// painter with a 7-bit command per note, and judges pad rising edges inside a
// hit window, keeping saturating hit and miss counts.
//
// Handshake: start is a single-cycle request pulse with no ready/ack. It is
// accepted only in IDLE or DONE. While playing=1 it is ignored and is not queued.
//
// Beat timing: the timer reads 0 in the LATCH cycle and increments every cycle
// after that. A note state leaves when the timer reads BEAT_TICKS-2, so the
// following FETCH cycle carries the final tick (BEAT_TICKS-1) of the old beat.
// The next LATCH then clears the timer again. LATCH to LATCH is therefore
// exactly BEAT_TICKS cycles, with no drift.
module note_scheduler #(
    parameter int BEAT_TICKS   = 25000000,
    parameter int WINDOW_TICKS = 12500000,
    parameter int SONG_LEN     = 64,
    parameter int ADDR_W       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        pad,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [6:0]        paint_cmd,
    output logic [7:0]        score,
    output logic [7:0]        misses,
    output logic              playing,
    output logic              done
);

    localparam int TIMER_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [TIMER_W-1:0] BEAT_LAST = TIMER_W'(BEAT_TICKS - 1);
    localparam logic [TIMER_W-1:0] BEAT_EXIT = TIMER_W'(BEAT_TICKS - 2);
    localparam logic [TIMER_W-1:0] WIN_END   = TIMER_W'(WINDOW_TICKS);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SHOW  = 3'd3,
        HIT   = 3'd4,
        MISS  = 3'd5,
        REST  = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [4:0]           note;
    logic [4:0]           pad_q;
    logic [4:0]           pad_rise;
    logic                 window_open;
    logic                 beat_exit;

    assign pad_rise    = pad & ~pad_q;
    assign window_open = (timer < WIN_END);
    assign beat_exit   = (timer == BEAT_EXIT);
    assign playing     = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic is_one_hot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // Sequencer FSM, beat timer, pad edge register, counters and painter command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            rom_addr  <= '0;
            paint_cmd <= 7'd0;
            score     <= 8'd0;
            misses    <= 8'd0;
            note      <= 5'd0;
            pad_q     <= 5'd0;
        end else begin
            pad_q <= pad;
            case (state)
                IDLE, DONE: begin
                    paint_cmd <= 7'd0;
                    if (start) begin
                        score     <= 8'd0;
                        misses    <= 8'd0;
                        rom_addr  <= '0;
                        paint_cmd <= 7'b0000001;
                        // Load the final tick so the first FETCH mirrors a beat tail.
                        timer     <= BEAT_LAST;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    paint_cmd <= 7'd0;
                    timer     <= '0;
                    state     <= LATCH;
                end
                LATCH: begin
                    note  <= rom_data;
                    timer <= timer + 1'b1;
                    if (is_one_hot(rom_data)) begin
                        paint_cmd <= {rom_data, 2'b00};
                        state     <= SHOW;
                    end else begin
                        paint_cmd <= 7'd0;
                        state     <= REST;
                    end
                end
                SHOW: begin
                    timer <= timer + 1'b1;
                    if (beat_exit) begin
                        // Last note cycle: judge whatever happened now, then advance.
                        if (window_open && (pad_rise == note))
                            score <= sat_inc(score);
                        else
                            misses <= sat_inc(misses);
                        paint_cmd <= 7'd0;
                        if (rom_addr == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end else if (window_open && (pad_rise != 5'd0)) begin
                        if (pad_rise == note) begin
                            score     <= sat_inc(score);
                            paint_cmd <= 7'b0000010;
                            state     <= HIT;
                        end else begin
                            misses    <= sat_inc(misses);
                            paint_cmd <= 7'd0;
                            state     <= MISS;
                        end
                    end else if (!window_open) begin
                        misses    <= sat_inc(misses);
                        paint_cmd <= 7'd0;
                        state     <= MISS;
                    end
                end
                HIT, MISS, REST: begin
                    timer <= timer + 1'b1;
                    if (beat_exit) begin
                        paint_cmd <= 7'd0;
                        if (rom_addr == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: a directed song run on a small pattern, plus a long
// single-lane song on a second instance to drive the hit counter into saturation.
module tb_note_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] pad;
    logic [1:0] rom_addr;
    logic [4:0] rom_data;
    logic [6:0] paint_cmd;
    logic [7:0] score;
    logic [7:0] misses;
    logic       playing;
    logic       done;

    logic       start2;
    logic [4:0] pad2;
    logic [8:0] rom_addr2;
    logic [4:0] rom_data2;
    logic [6:0] paint_cmd2;
    logic [7:0] score2;
    logic [7:0] misses2;
    logic       playing2;
    logic       done2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    logic [4:0] rom_mem [4] = '{5'b00001, 5'b00000, 5'b00100, 5'b00011};

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    // Pattern ROMs: data valid one cycle after the address.
    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];
    assign rom_data2 = 5'b00001;

    note_scheduler #(.BEAT_TICKS(8), .WINDOW_TICKS(4), .SONG_LEN(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pad(pad),
        .rom_addr(rom_addr), .rom_data(rom_data), .paint_cmd(paint_cmd),
        .score(score), .misses(misses), .playing(playing), .done(done)
    );

    note_scheduler #(.BEAT_TICKS(4), .WINDOW_TICKS(2), .SONG_LEN(260)) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .pad(pad2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .paint_cmd(paint_cmd2),
        .score(score2), .misses(misses2), .playing(playing2), .done(done2)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_paint(input logic [6:0] v);
        int i = 0;
        while (paint_cmd !== v && i < 64) begin
            tick();
            i++;
        end
        check("wait_paint", 32'(paint_cmd), 32'(v));
    endtask

    task automatic wait_addr(input logic [1:0] a);
        int i = 0;
        while (rom_addr !== a && i < 64) begin
            tick();
            i++;
        end
        check("wait_addr", 32'(rom_addr), 32'(a));
    endtask

    task automatic wait_done();
        int i = 0;
        while (done !== 1'b1 && i < 64) begin
            tick();
            i++;
        end
        check("wait_done", 32'(done), 32'd1);
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_push(input logic [7:0] s, input logic [7:0] m);
        exp_q.push_back({s, m});
    endtask

    task automatic sb_check(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'({score, misses}), 32'(e));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; pad = 5'd0;
        start2 = 1'b0; pad2 = 5'd0;
        repeat (3) tick();
        check("rst_paint", 32'(paint_cmd), 32'd0);
        check("rst_counts", 32'({score, misses}), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_flags", 32'({playing, done}), 32'd0);
        reset = 1'b0;
        tick();

        // Song 1: hit, rest, wrong lane, multi-bit rest.
        pulse_start();
        check("start_paint", 32'(paint_cmd), 32'h01);
        check("start_playing", 32'(playing), 32'd1);
        tick();
        check("start_pulse_len", 32'(paint_cmd), 32'h00);
        wait_paint(7'h04);
        tick();
        pad = 5'b00001;
        tick();
        check("hit_flash", 32'(paint_cmd), 32'h02);
        check("hit_score", 32'(score), 32'd1);
        sb_push(8'd1, 8'd0);
        wait_addr(2'd1);
        sb_check("beat0_counts");
        repeat (2) tick();
        check("rest_paint", 32'(paint_cmd), 32'h00);
        pad = 5'd0;
        sb_push(8'd1, 8'd0);
        wait_addr(2'd2);
        sb_check("beat1_counts");
        wait_paint(7'h10);
        pad = 5'b00010;
        tick();
        check("wrong_lane_paint", 32'(paint_cmd), 32'h00);
        check("wrong_lane_miss", 32'(misses), 32'd1);
        pad = 5'b00110;
        repeat (2) tick();
        pad = 5'd0;
        sb_push(8'd1, 8'd1);
        wait_addr(2'd3);
        sb_check("beat2_counts");
        sb_push(8'd1, 8'd1);
        wait_done();
        sb_check("beat3_counts");
        check("done_playing", 32'(playing), 32'd0);
        check("done_paint", 32'(paint_cmd), 32'h00);

        // Song 2: restart from DONE, silent window, ignored start, simultaneous lanes.
        tick();
        pulse_start();
        check("restart_counts", 32'({score, misses}), 32'd0);
        check("restart_flags", 32'({playing, done}), 32'b10);
        wait_paint(7'h04);
        repeat (2) tick();
        check("window_open_no_miss", 32'(misses), 32'd0);
        repeat (2) tick();
        check("window_close_miss", 32'(misses), 32'd1);
        check("window_close_paint", 32'(paint_cmd), 32'h00);
        sb_push(8'd0, 8'd1);
        wait_addr(2'd1);
        sb_check("s2_beat0_counts");
        repeat (2) tick();
        pulse_start();
        check("start_ignored_addr", 32'(rom_addr), 32'd1);
        check("start_ignored_flags", 32'({playing, done}), 32'b10);
        sb_push(8'd0, 8'd1);
        wait_addr(2'd2);
        sb_check("s2_beat1_counts");
        wait_paint(7'h10);
        pad = 5'b00101;
        tick();
        check("multi_rise_miss", 32'({score, misses}), 32'h0002);
        pad = 5'd0;
        sb_push(8'd0, 8'd2);
        wait_addr(2'd3);
        sb_check("s2_beat2_counts");
        sb_push(8'd0, 8'd2);
        wait_done();
        sb_check("s2_beat3_counts");

        // Saturation: 260 hits on the second instance.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done2 === 1'b1) break;
            if (paint_cmd2 === 7'h04 && pad2 == 5'd0) pad2 = 5'b00001;
            else pad2 = 5'd0;
            tick();
        end
        pad2 = 5'd0;
        check("sat_done", 32'(done2), 32'd1);
        check("sat_score", 32'(score2), 32'd255);
        check("sat_misses", 32'(misses2), 32'd0);
        check("sat_addr", 32'(rom_addr2), 32'd259);

        // Song 3: reset while a note is showing.
        tick();
        pulse_start();
        wait_paint(7'h04);
        pad = 5'b00001;
        tick();
        pad = 5'd0;
        check("s3_hit", 32'(score), 32'd1);
        wait_paint(7'h10);
        reset = 1'b1;
        tick();
        check("midrst_paint", 32'(paint_cmd), 32'h00);
        check("midrst_counts", 32'({score, misses}), 32'd0);
        check("midrst_flags", 32'({playing, done}), 32'd0);
        check("midrst_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
